// File: rtl/potential_update_sequencer_pkg.sv
// Shared definitions for the potential update sequencer: FP32 field layout,
// FSM state encodings and the adder's default firing threshold.
package potential_pkg;

    typedef logic [31:0] fp32_t;

    localparam int unsigned EXP_MSB   = 30;
    localparam int unsigned EXP_LSB   = 23;
    localparam logic [7:0]  EXP_INF   = 8'hFF;
    localparam fp32_t       THRESHOLD = 32'h4287C7AE;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_INIT  = 3'd1;
    localparam logic [2:0] S_ISSUE = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_WRITE = 3'd4;
    localparam logic [2:0] S_EMIT  = 3'd5;
    localparam logic [2:0] S_NEXT  = 3'd6;
    localparam logic [2:0] S_DONE  = 3'd7;

endpackage

// File: rtl/potential_update_sequencer_if.sv
// Bundle of control, weight-write, adder and spike-stream signals around the sequencer.
// master = sequencer side, slave = surrounding NoC / adder / packetiser side.
interface potential_update_sequencer_if
    import potential_pkg::*;
#(
    parameter int unsigned ID_W = 4
);
    logic            timestep_start;
    logic [3:0]      cfg_decay_shift;
    logic            wr_en;
    logic [ID_W-1:0] wr_addr;
    fp32_t           wr_data;
    logic            wr_drop;
    logic            busy;
    logic            done;
    logic            adder_set;
    logic            adder_clear;
    fp32_t           adder_weight;
    fp32_t           adder_potential;
    fp32_t           adder_result;
    logic            adder_spike;
    logic            spike_valid;
    logic            spike_ready;
    logic [ID_W-1:0] spike_id;

    modport master (
        input  timestep_start, cfg_decay_shift, wr_en, wr_addr, wr_data,
               adder_result, adder_spike, spike_ready,
        output wr_drop, busy, done, adder_set, adder_clear,
               adder_weight, adder_potential, spike_valid, spike_id
    );

    modport slave (
        output timestep_start, cfg_decay_shift, wr_en, wr_addr, wr_data,
               adder_result, adder_spike, spike_ready,
        input  wr_drop, busy, done, adder_set, adder_clear,
               adder_weight, adder_potential, spike_valid, spike_id
    );

endinterface

// File: rtl/potential_update_sequencer_fp_pow2_decay.sv
// Combinational FP32 multiply by 2^-k done purely on the exponent field;
// underflow flushes to zero, Inf/NaN pass through untouched.
module fp_pow2_decay
    import potential_pkg::*;
(
    input  fp32_t      i_value,
    input  logic [3:0] i_shift,
    output fp32_t      o_value
);

    logic [7:0] w_exp;
    logic [7:0] w_shift;

    assign w_exp   = i_value[EXP_MSB:EXP_LSB];
    assign w_shift = {4'b0000, i_shift};

    always_comb begin
        o_value = i_value;
        if (w_exp == EXP_INF) begin
            o_value = i_value;
        end else if (w_exp == '0) begin
            o_value = '0;
        end else if (i_shift == '0) begin
            o_value = i_value;
        end else if (w_exp <= w_shift) begin
            o_value = '0;
        end else begin
            o_value = {i_value[31], w_exp - w_shift, i_value[22:0]};
        end
    end

endmodule

// File: rtl/potential_update_sequencer.sv
// Per-timestep walker over all neurons: decays each stored potential, feeds the external
// adder, writes the result back, clears the consumed weight and streams spiking neuron IDs.
module potential_update_sequencer
    import potential_pkg::*;
#(
    parameter int unsigned N_NEURONS = 16,
    parameter int unsigned ID_W      = 4,
    parameter int unsigned ADDER_LAT = 1
)(
    input  logic                         clk,
    input  logic                         rst,
    potential_update_sequencer_if.master bus
);

    localparam int unsigned   WAIT_W    = (ADDER_LAT > 1) ? $clog2(ADDER_LAT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ADDER_LAT - 1);
    localparam logic [ID_W-1:0]   IDX_LAST  = ID_W'(N_NEURONS - 1);

    logic [2:0]        r_state;
    logic [ID_W-1:0]   r_idx;
    logic [WAIT_W-1:0] r_wait;
    logic [3:0]        r_k;
    fp32_t             r_adder_weight;
    fp32_t             r_adder_potential;
    logic              r_wr_drop;
    fp32_t             r_pot [N_NEURONS];
    fp32_t             r_wgt [N_NEURONS];

    logic              w_busy;
    fp32_t             w_decayed;

    fp_pow2_decay u_decay (
        .i_value (r_pot[r_idx]),
        .i_shift (r_k),
        .o_value (w_decayed)
    );

    assign w_busy = (r_state != S_IDLE) && (r_state != S_DONE);

    // Writes only land outside a pass, so they never collide with the WRITE-state clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < N_NEURONS; i++) begin
                r_pot[i] <= '0;
                r_wgt[i] <= '0;
            end
        end else begin
            if (bus.wr_en && !w_busy) begin
                r_wgt[bus.wr_addr] <= bus.wr_data;
            end
            if (r_state == S_WRITE) begin
                r_pot[r_idx] <= bus.adder_result;
                r_wgt[r_idx] <= '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state           <= S_IDLE;
            r_idx             <= '0;
            r_wait            <= '0;
            r_k               <= '0;
            r_adder_weight    <= '0;
            r_adder_potential <= '0;
            r_wr_drop         <= 1'b0;
        end else begin
            r_wr_drop <= bus.wr_en && w_busy;
            case (r_state)
                S_IDLE: begin
                    if (bus.timestep_start) begin
                        r_state <= S_INIT;
                        r_idx   <= '0;
                        r_k     <= bus.cfg_decay_shift;
                    end
                end
                S_INIT:  r_state <= S_ISSUE;
                S_ISSUE: begin
                    r_adder_weight    <= r_wgt[r_idx];
                    r_adder_potential <= w_decayed;
                    r_wait            <= '0;
                    r_state           <= S_WAIT;
                end
                S_WAIT: begin
                    if (r_wait == WAIT_LAST) begin
                        r_state <= S_WRITE;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                S_WRITE: r_state <= bus.adder_spike ? S_EMIT : S_NEXT;
                S_EMIT: begin
                    if (bus.spike_ready) begin
                        r_state <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    if (r_idx == IDX_LAST) begin
                        r_state <= S_DONE;
                    end else begin
                        r_idx   <= r_idx + 1'b1;
                        r_state <= S_ISSUE;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy            = w_busy;
    assign bus.done            = (r_state == S_DONE);
    assign bus.wr_drop         = r_wr_drop;
    assign bus.adder_set       = (r_state == S_INIT);
    assign bus.adder_clear     = (r_state == S_IDLE) || (r_state == S_DONE);
    assign bus.adder_weight    = r_adder_weight;
    assign bus.adder_potential = r_adder_potential;
    assign bus.spike_valid     = (r_state == S_EMIT);
    assign bus.spike_id        = r_idx;

endmodule
